// File: rtl/seq_det_pkg.sv
// Shared types for the programmable serial pattern detector.
package seq_det_pkg;
  typedef enum logic [1:0] {
    UNCFG = 2'd0,
    FILL  = 2'd1,
    HUNT  = 2'd2,
    HIT   = 2'd3
  } state_t;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; a clear coinciding with an increment leaves the count at one.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
    return (&v) ? v : v + WIDTH'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (clr)
      count <= inc ? WIDTH'(1) : '0;
    else if (inc)
      count <= sat_inc(count);
  end

endmodule

// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial pattern detector (1..MAX_LEN bits) with
// overlap control, qualified input stream and a saturating hit counter.
module seq_detector_prog
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic                         in_bit,
  input  logic                         cfg_load,
  input  logic [MAX_LEN-1:0]           cfg_pattern,
  input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
  input  logic                         cfg_overlap,
  input  logic                         cnt_clr,
  output logic                         match,
  output logic [CNT_W-1:0]             match_count,
  output logic                         cfg_err,
  output logic                         armed
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);

  state_t             state, state_n, b_state;
  logic [MAX_LEN-1:0] pattern, pattern_n;
  logic [LEN_W-1:0]   len, len_n;
  logic               overlap, overlap_n;
  logic [MAX_LEN-1:0] window, window_n, b_window, win_sh, mask;
  logic [LEN_W-1:0]   fill, fill_n, b_fill, fill_inc;
  logic               cfg_err_n, cfg_legal, cmp;

  always_comb begin
    state_n   = state;
    pattern_n = pattern;
    len_n     = len;
    overlap_n = overlap;
    window_n  = window;
    fill_n    = fill;
    cfg_err_n = 1'b0;

    // A non-overlapping hit restarts from an empty window, exactly as FILL would.
    if (state == HIT && !overlap) begin
      b_state  = FILL;
      b_window = '0;
      b_fill   = '0;
    end else begin
      b_state  = state;
      b_window = window;
      b_fill   = fill;
    end

    win_sh    = (b_window << 1) | MAX_LEN'(in_bit);
    mask      = ~({MAX_LEN{1'b1}} << len);
    cmp       = ((win_sh ^ pattern) & mask) == '0;
    fill_inc  = b_fill + LEN_W'(1);
    cfg_legal = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));

    if (cfg_load) begin
      if (cfg_legal) begin
        pattern_n = cfg_pattern;
        len_n     = cfg_len;
        overlap_n = cfg_overlap;
        window_n  = '0;
        fill_n    = '0;
        state_n   = FILL;
      end else begin
        cfg_err_n = 1'b1;
      end
    end else if (state != UNCFG) begin
      state_n  = b_state;
      window_n = b_window;
      fill_n   = b_fill;
      if (in_valid) begin
        window_n = win_sh;
        if (b_state == FILL) begin
          fill_n = fill_inc;
          if (fill_inc == len)
            state_n = cmp ? HIT : HUNT;
        end else begin
          state_n = cmp ? HIT : HUNT;
        end
      end else if (b_state == HIT) begin
        state_n = HUNT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= UNCFG;
      pattern <= '0;
      len     <= '0;
      overlap <= 1'b0;
      window  <= '0;
      fill    <= '0;
      match   <= 1'b0;
      cfg_err <= 1'b0;
      armed   <= 1'b0;
    end else begin
      state   <= state_n;
      pattern <= pattern_n;
      len     <= len_n;
      overlap <= overlap_n;
      window  <= window_n;
      fill    <= fill_n;
      match   <= (state_n == HIT);
      cfg_err <= cfg_err_n;
      armed   <= (state_n != UNCFG);
    end
  end

  // HIT is only ever entered on an accepted bit, so every cycle headed for HIT is a hit.
  sat_counter #(.WIDTH(CNT_W)) u_hits (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (state_n == HIT),
    .count (match_count)
  );

endmodule

// File: tb/tb_seq_detector_prog.sv
// Table-driven bench for seq_detector_prog with a per-cycle expected-output queue.
module tb_seq_detector_prog;
  import seq_det_pkg::*;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 2;

  logic             clk = 1'b0;
  logic             rst, in_valid, in_bit, cfg_load, cfg_overlap, cnt_clr;
  logic [7:0]       cfg_pattern;
  logic [3:0]       cfg_len;
  logic             match, cfg_err, armed;
  logic [CNT_W-1:0] match_count;

  seq_detector_prog #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_bit      (in_bit),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cnt_clr     (cnt_clr),
    .match       (match),
    .match_count (match_count),
    .cfg_err     (cfg_err),
    .armed       (armed)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r, ld;
    logic [7:0] pat;
    logic [3:0] ln;
    logic       ov, vl, b, cl;
    logic       em;
    logic [1:0] ec;
    logic       ee, ea;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic vec_t v(input logic r, ld, input logic [7:0] pat, input logic [3:0] ln,
                             input logic ov, vl, b, cl, em, input logic [1:0] ec,
                             input logic ee, ea);
    vec_t t;
    t.r = r; t.ld = ld; t.pat = pat; t.ln = ln; t.ov = ov; t.vl = vl; t.b = b; t.cl = cl;
    t.em = em; t.ec = ec; t.ee = ee; t.ea = ea;
    return t;
  endfunction

  function automatic vec_t sb(input logic b, em, input logic [1:0] ec, input logic ea);
    return v(0, 0, 8'h00, 4'd0, 0, 1, b, 0, em, ec, 0, ea);
  endfunction

  function automatic vec_t idl(input logic [1:0] ec, input logic ea);
    return v(0, 0, 8'h00, 4'd0, 0, 0, 1, 0, 0, ec, 0, ea);
  endfunction

  function automatic vec_t ldv(input logic [7:0] pat, input logic [3:0] ln, input logic ov,
                               input logic ee, input logic [1:0] ec, input logic ea);
    return v(0, 1, pat, ln, ov, 0, 0, 0, 0, ec, ee, ea);
  endfunction

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s step %0d: got %0h, expected %0h", name, idx, act, req);
    end
  endtask

  task automatic apply(input vec_t t, input int idx);
    vec_t e;
    @(negedge clk);
    rst = t.r; cfg_load = t.ld; cfg_pattern = t.pat; cfg_len = t.ln; cfg_overlap = t.ov;
    in_valid = t.vl; in_bit = t.b; cnt_clr = t.cl;
    exp_q.push_back(t);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("match", idx, {7'd0, match}, {7'd0, e.em});
    chk("match_count", idx, {6'd0, match_count}, {6'd0, e.ec});
    chk("cfg_err", idx, {7'd0, cfg_err}, {7'd0, e.ee});
    chk("armed", idx, {7'd0, armed}, {7'd0, e.ea});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; cfg_load = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    in_valid = 1'b0; in_bit = 1'b0; cnt_clr = 1'b0;

    // reset, then bits with no configuration
    tbl.push_back(v(1, 0, 8'h00, 4'd0, 0, 0, 0, 0, 0, 2'd0, 0, 0));
    tbl.push_back(sb(1, 0, 0, 0)); tbl.push_back(sb(0, 0, 0, 0));
    tbl.push_back(sb(0, 0, 0, 0)); tbl.push_back(sb(1, 0, 0, 0));
    // 1001 overlapping, stream 1001001
    tbl.push_back(ldv(8'h09, 4'd4, 1, 0, 0, 1));
    tbl.push_back(sb(1, 0, 0, 1)); tbl.push_back(sb(0, 0, 0, 1)); tbl.push_back(sb(0, 0, 0, 1));
    tbl.push_back(sb(1, 1, 1, 1)); tbl.push_back(sb(0, 0, 1, 1)); tbl.push_back(sb(0, 0, 1, 1));
    tbl.push_back(sb(1, 1, 2, 1)); tbl.push_back(idl(2, 1));
    tbl.push_back(v(0, 0, 8'h00, 4'd0, 0, 0, 0, 1, 0, 2'd0, 0, 1));
    // 1001 non-overlapping, stream 1001001 then 001
    tbl.push_back(ldv(8'h09, 4'd4, 0, 0, 0, 1));
    tbl.push_back(sb(1, 0, 0, 1)); tbl.push_back(sb(0, 0, 0, 1)); tbl.push_back(sb(0, 0, 0, 1));
    tbl.push_back(sb(1, 1, 1, 1)); tbl.push_back(sb(0, 0, 1, 1)); tbl.push_back(sb(0, 0, 1, 1));
    tbl.push_back(sb(1, 0, 1, 1)); tbl.push_back(sb(0, 0, 1, 1)); tbl.push_back(sb(0, 0, 1, 1));
    tbl.push_back(sb(1, 1, 2, 1)); tbl.push_back(idl(2, 1));
    // illegal lengths keep the previous config
    tbl.push_back(ldv(8'hFF, 4'd0, 1, 1, 2, 1));
    tbl.push_back(ldv(8'hFF, 4'd9, 1, 1, 2, 1));
    tbl.push_back(idl(2, 1));
    tbl.push_back(sb(1, 0, 2, 1)); tbl.push_back(sb(0, 0, 2, 1)); tbl.push_back(sb(0, 0, 2, 1));
    tbl.push_back(sb(1, 1, 3, 1));
    tbl.push_back(v(0, 0, 8'h00, 4'd0, 0, 0, 0, 1, 0, 2'd0, 0, 1));
    // gap of 5 invalid cycles inside a partial match
    tbl.push_back(sb(1, 0, 0, 1)); tbl.push_back(sb(0, 0, 0, 1));
    for (int i = 0; i < 5; i++) tbl.push_back(idl(0, 1));
    tbl.push_back(sb(0, 0, 0, 1)); tbl.push_back(sb(1, 1, 1, 1)); tbl.push_back(idl(1, 1));

    foreach (tbl[i]) apply(tbl[i], i);

    // load coinciding with a completing bit: bit dropped, detection restarts from empty
    apply(sb(1, 0, 1, 1), 100); apply(sb(0, 0, 1, 1), 101); apply(sb(0, 0, 1, 1), 102);
    apply(v(0, 1, 8'h09, 4'd4, 0, 1, 1, 0, 0, 2'd1, 0, 1), 103);
    apply(sb(1, 0, 1, 1), 104); apply(sb(0, 0, 1, 1), 105); apply(sb(0, 0, 1, 1), 106);
    apply(sb(1, 1, 2, 1), 107); apply(idl(2, 1), 108);

    // full-length pattern 10100101
    apply(ldv(8'hA5, 4'd8, 1, 0, 2, 1), 110);
    for (int i = 7; i >= 0; i--) begin
      logic [7:0] p;
      p = 8'hA5;
      apply(sb(p[i], (i == 0), (i == 0) ? 2'd3 : 2'd2, 1), 111 + (7 - i));
    end
    apply(sb(0, 0, 3, 1), 119);

    // single-bit pattern: saturation and clear-with-hit
    apply(ldv(8'h01, 4'd1, 1, 0, 3, 1), 120);
    apply(v(0, 0, 8'h00, 4'd0, 0, 0, 0, 1, 0, 2'd0, 0, 1), 121);
    for (int i = 0; i < 5; i++) apply(sb(1, 1, (i < 3) ? 2'(i + 1) : 2'd3, 1), 122 + i);
    apply(v(0, 0, 8'h00, 4'd0, 0, 1, 1, 1, 1, 2'd1, 0, 1), 127);
    apply(sb(0, 0, 1, 1), 128);

    // reset mid-pattern loses configuration
    apply(ldv(8'h09, 4'd4, 1, 0, 1, 1), 130);
    apply(sb(1, 0, 1, 1), 131); apply(sb(0, 0, 1, 1), 132); apply(sb(0, 0, 1, 1), 133);
    apply(v(1, 0, 8'h00, 4'd0, 0, 1, 1, 0, 0, 2'd0, 0, 0), 134);
    apply(sb(1, 0, 0, 0), 135); apply(sb(0, 0, 0, 0), 136);
    apply(sb(0, 0, 0, 0), 137); apply(sb(1, 0, 0, 0), 138);

    if (exp_q.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_detector_prog.md
# seq_detector_prog

Runtime-programmable serial pattern detector. It generalises the fixed 1001 Moore detector to any pattern of 1..MAX_LEN bits loaded at run time. It adds a qualified input stream, selectable overlapping/non-overlapping matching and a saturating hit counter. It sits on single-bit serial links (framing/sync-word hunt) and feeds status registers.

## Interface
- MAX_LEN, 8, maximum pattern length in bits (≥1)
- CNT_W, 8, width of hit counter
- LEN_W, $clog2(MAX_LEN+1), width of length field (derived, not overridden)
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  qualifies in_bit; bit accepted on edge where in_valid=1
- in_bit  in  1  serial data bit
- cfg_load  in  1  one-cycle pulse: load cfg_pattern/cfg_len/cfg_overlap
- cfg_pattern  in  MAX_LEN  pattern; bit [cfg_len-1] is first bit received, bit [0] last
- cfg_len  in  LEN_W  pattern length, legal 1..MAX_LEN
- cfg_overlap  in  1  1 = overlapping matches, 0 = non-overlapping
- cnt_clr  in  1  clear hit counter
- match  out  1  Moore output, high while FSM in HIT
- match_count  out  CNT_W  saturating number of hits since reset/clear
- cfg_err  out  1  one-cycle pulse: cfg_load rejected (illegal cfg_len)
- armed  out  1  high when a valid configuration is held (state ≠ UNCFG)

## Operation
- Window: MAX_LEN-bit shift register; accepted bit shifts in at LSB. Compare (window & mask) == (pattern & mask), mask = low cfg_len bits.
- fill counter (LEN_W) counts accepted bits since window was last cleared, saturating at cfg_len.
- States: UNCFG, FILL, HUNT, HIT.
  - UNCFG: in_valid ignored; only legal cfg_load leaves.
  - FILL: accepted bit → fill+1; if fill reaches len and compare true → HIT; reaches len, false → HUNT; else stay.
  - HUNT: accepted bit → compare true ? HIT : HUNT.
  - HIT, overlap=1: accepted bit → treated as from HUNT; no bit → HUNT.
  - HIT, overlap=0: window and fill cleared; an accepted bit in this cycle becomes the first bit of the new window (fill=1, HIT again only if len=1); no bit → FILL with fill=0.
- Legal cfg_load (1 ≤ cfg_len ≤ MAX_LEN): registers config, clears window/fill → FILL. Allowed in any state. Illegal: config unchanged, state unchanged, cfg_err=1 next cycle.
- cfg_load and in_valid in the same cycle: load wins, bit dropped.
- match_count increments on every entry into or re-entry of HIT; saturates at 2^CNT_W-1. cnt_clr with a coincident hit → count=1. cnt_clr alone → 0.

## Timing
- Reset values: state UNCFG, pattern 0, len 0, overlap 0, window 0, fill 0, match 0, match_count 0, cfg_err 0, armed 0.
- Latency: bit completing a pattern accepted at edge k → match=1 from edge k to edge k+1. Count is updated at the same edge k.
- match stays high across consecutive cycles only if each cycle accepts another completing bit.
- in_valid=0 gaps freeze window/fill; gaps do not break a partial match.
- armed=1 from the edge after a legal cfg_load.
- rst mid-stream: all state returns to reset values at that edge; configuration is lost and a reload is needed.

## Structure
- Package seq_det_pkg: state enum typedef (state_t: UNCFG, FILL, HUNT, HIT), shared by RTL and bench.
- Sub-module sat_counter (WIDTH param; inc, clr inputs; clr+inc → 1) for match_count.
- Single always_ff for state/window/fill/config; always_comb for next state and compare.

## Test plan
- Reset, then in_valid=1 with bits, no cfg_load → match=0, armed=0, count=0.
- Load 1001/len 4/overlap=1, stream 1001001 → match pulses after bits 4 and 7, count=2.
- Same pattern, overlap=0, stream 1001001 → one pulse after bit 4, count=1; then add bits 001 → second pulse after bit 10.
- Load len=0 and len=MAX_LEN+1 → cfg_err pulse each, previous config still detects 1001.
- Stream 10, in_valid low 5 cycles, then 01 → match after final bit. A cfg_load in the same cycle as a completing bit → bit dropped, no match, state FILL.
- CNT_W=2, pattern 1 len 1 overlap, 5 ones → count saturates at 3. cnt_clr with a hit → count 1. rst mid-pattern → all outputs 0, armed 0.
